// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame constants and timing helpers.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERR
  } ps2_state_t;

  localparam int PS2_DATA_BITS   = 8;
  localparam int PS2_LAST_TX_BIT = 9;

  function automatic int cycles_from_us(input int freq, input int us);
    return int'((longint'(freq) * longint'(us)) / longint'(1_000_000));
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stability filter for a PS/2 line; emits 1-cycle fall/rise pulses.
// The filtered level follows the line only after FILTER_LEN consecutive equal samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic fall,
  output logic rise
);
  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      fall <= 1'b0;
      rise <= 1'b0;
      // cnt tracks how many samples in a row have disagreed with the accepted level
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        level <= sync;
        cnt   <= '0;
        fall  <= level;
        rise  <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked shift, ack check.
// Accepts one byte only in IDLE (tx_ready); tx_valid while busy is ignored.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int INHIBIT_CYCLES = cycles_from_us(CLK_FREQ_HZ, 100),
  parameter int REQ_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = cycles_from_us(CLK_FREQ_HZ, 20_000),
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BIT_W  = $clog2(PS2_LAST_TX_BIT + 2);

  ps2_state_t               state;
  ps2_state_t               state_nxt;
  logic [PH_W-1:0]          ph_cnt;
  logic [TO_W-1:0]          to_cnt;
  logic [BIT_W-1:0]         bitcnt;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic                     par;
  logic                     data_q;
  logic                     data_meta;
  logic                     data_sync;
  logic                     clk_level;
  logic                     clk_fall;
  logic                     clk_rise;
  logic                     to_hit;
  logic                     in_frame;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk  (clk),
    .reset(reset),
    .raw  (ps2_clk_i),
    .level(clk_level),
    .fall (clk_fall),
    .rise (clk_rise)
  );

  // A simultaneous fall and rise would mean the filter lost track of its level.
  clk_edges_exclusive: assert property (@(posedge clk) disable iff (reset) !(clk_fall && clk_rise));

  always_ff @(posedge clk) begin
    if (reset) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= ps2_data_i;
      data_sync <= data_meta;
    end
  end

  assign in_frame = (state == ST_SHIFT) || (state == ST_ACK) || (state == ST_WAIT_IDLE);
  assign to_hit   = in_frame && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    tx_ready    = 1'b0;
    busy        = 1'b1;
    tx_done     = 1'b0;
    tx_error    = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) state_nxt = ST_INHIBIT;
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (ph_cnt == PH_W'(INHIBIT_CYCLES - 1)) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        if (ph_cnt == PH_W'(REQ_CYCLES - 1)) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        ps2_data_oe = data_q;
        if (to_hit) state_nxt = ST_ERR;
        else if (clk_fall && bitcnt == BIT_W'(PS2_LAST_TX_BIT)) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        if (to_hit) state_nxt = ST_ERR;
        else if (clk_fall) state_nxt = data_sync ? ST_ERR : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (to_hit) state_nxt = ST_ERR;
        else if (clk_level && data_sync) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        tx_done   = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        tx_error  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph_cnt <= '0;
      to_cnt <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      data_q <= 1'b0;
    end else begin
      ph_cnt <= ((state == ST_INHIBIT || state == ST_REQ) && state_nxt == state) ? ph_cnt + 1'b1 : '0;
      // Timeout only runs once the device owns the clock; REQ leaves it cleared.
      to_cnt <= in_frame ? to_cnt + 1'b1 : '0;

      if (state == ST_IDLE && tx_valid) begin
        shreg  <= tx_data;
        par    <= ~^tx_data;
        bitcnt <= '0;
        data_q <= 1'b1;
      end else if (state == ST_SHIFT && clk_fall && !to_hit) begin
        bitcnt <= bitcnt + 1'b1;
        if (bitcnt < BIT_W'(PS2_DATA_BITS)) begin
          data_q <= ~shreg[0];
          shreg  <= shreg >> 1;
        end else if (bitcnt == BIT_W'(PS2_DATA_BITS)) begin
          data_q <= ~par;
        end else begin
          data_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device BFM on a wired-AND PS/2 pair, frame-level model and per-cycle checker.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH  = 500;
  localparam int REQ  = 50;
  localparam int TMO  = 10000;
  localparam int FLT  = 8;
  localparam int HALF = 150;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0;
  logic       ps2_clk_i, ps2_data_i;

  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe & ~glitch;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .CLK_FREQ_HZ   (5_000_000),
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQ),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, acc = 0, k = 0, mode = 0, done_cnt = 0, err_cnt = 0;
  bit mb = 1'b0, pulse_seen = 1'b0, fall11 = 1'b0, rise11 = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bits the device must see on its rising edges: data LSB first, odd parity, stop.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

  // Modes: 0 device acks, 1 device withholds ack, 2 device never clocks, 3 frame aborted by reset.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      mb = 1'b0;
      pulse_seen = 1'b0;
    end else if (mb && pulse_seen) begin
      mb = 1'b0;
      pulse_seen = 1'b0;
    end else if (!mb && tx_valid) begin
      mb = 1'b1;
      acc = cyc;
    end

    if (!mb) begin
      chk1("idle_tx_ready", tx_ready, 1'b1);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_clk_oe", ps2_clk_oe, 1'b0);
      chk1("idle_data_oe", ps2_data_oe, 1'b0);
      chk1("idle_tx_done", tx_done, 1'b0);
      chk1("idle_tx_error", tx_error, 1'b0);
    end else begin
      k = cyc - acc;
      chk1("busy_tx_ready", tx_ready, 1'b0);
      chk1("busy_busy", busy, 1'b1);
      if (k < INH) begin
        chk1("inhibit_clk_oe", ps2_clk_oe, 1'b1);
        chk1("inhibit_data_oe", ps2_data_oe, 1'b0);
      end else if (k < INH + REQ) begin
        chk1("req_clk_oe", ps2_clk_oe, 1'b1);
        chk1("req_data_oe", ps2_data_oe, 1'b1);
      end else begin
        chk1("released_clk_oe", ps2_clk_oe, 1'b0);
      end
      chk1("done_error_exclusive", tx_done & tx_error, 1'b0);
      if (tx_done) begin
        chk1("done_allowed", (mode == 0) && rise11, 1'b1);
        done_cnt++;
        pulse_seen = 1'b1;
      end
      if (tx_error) begin
        chk1("error_allowed", ((mode == 1) && fall11) || ((mode == 2) && (k == INH + REQ + TMO)), 1'b1);
        chk1("error_data_oe", ps2_data_oe, 1'b0);
        err_cnt++;
        pulse_seen = 1'b1;
      end
      if (mode == 2 && k == INH + REQ + TMO) chk1("timeout_error_cycle", tx_error, 1'b1);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int w;
    w = 0;
    while (mb && w < bound) begin
      @(negedge clk);
      w++;
    end
    chk1("frame_completes", mb, 1'b0);
  endtask

  // Device side: waits for the request, then clocks npulses pulses and samples data on each rise.
  task automatic bfm(input int npulses, input bit ack, input int gpulse, output logic [9:0] got);
    int w;
    got = '0;
    w = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < INH + REQ + 200) begin
      @(negedge clk);
      w++;
    end
    chk1("request_seen", (ps2_clk_oe === 1'b0) && (ps2_data_oe === 1'b1), 1'b1);
    if (w >= INH + REQ + 200) return;
    repeat (HALF) @(negedge clk);
    chk1("start_bit", ps2_data_i, 1'b0);
    for (int j = 1; j <= npulses; j++) begin
      dev_clk = 1'b0;
      if (j == 11) begin
        fall11 = 1'b1;
        if (ack) dev_data = 1'b0;
      end
      if (j == npulses && npulses < 11) begin
        repeat (20) @(negedge clk);
        return;
      end
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (j <= 10) got[j-1] = ps2_data_i;
      if (j == 11) begin
        dev_data = 1'b1;
        rise11 = 1'b1;
      end
      if (j == gpulse) begin
        repeat (HALF / 2) @(negedge clk);
        glitch = 1'b1;
        repeat (5) @(negedge clk);
        glitch = 1'b0;
        repeat (HALF - HALF / 2 - 5) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input int m, input int gpulse, output logic [9:0] got);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    mode = m;
    fall11 = 1'b0;
    rise11 = 1'b0;
    send(b);
    bfm(11, m == 0, gpulse, got);
    wait_idle(4 * HALF);
    chkv("frame_bits", 32'(got), 32'(frame_of(b)));
    chkv("done_count", done_cnt - d0, (m == 0) ? 1 : 0);
    chkv("error_count", err_cnt - e0, (m == 1) ? 1 : 0);
  endtask

  initial begin
    logic [9:0] got;
    logic [2:0] low3;
    logic [7:0] b;
    int m, e0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk1("reset_tx_ready", tx_ready, 1'b1);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_clk_oe", ps2_clk_oe, 1'b0);
    chk1("reset_data_oe", ps2_data_oe, 1'b0);
    chk1("reset_tx_done", tx_done, 1'b0);
    chk1("reset_tx_error", tx_error, 1'b0);

    run_frame(8'hED, 0, 0, got);
    chkv("ed_literal_bits", 32'(got), 32'(10'b11_1110_1101));
    repeat (20) @(negedge clk);
    run_frame(8'h00, 0, 0, got);
    chk1("parity_00", got[8], 1'b1);
    repeat (20) @(negedge clk);
    run_frame(8'hFF, 0, 0, got);
    chk1("parity_ff", got[8], 1'b1);
    repeat (20) @(negedge clk);

    run_frame(8'h3C, 1, 0, got);
    chk1("noack_released_data", ps2_data_oe, 1'b0);
    repeat (20) @(negedge clk);

    mode = 2;
    e0 = err_cnt;
    send(8'h55);
    wait_idle(INH + REQ + TMO + 50);
    chkv("timeout_error_count", err_cnt - e0, 1);
    chk1("timeout_data_oe_after", ps2_data_oe, 1'b0);
    repeat (20) @(negedge clk);

    mode = 3;
    fall11 = 1'b0;
    rise11 = 1'b0;
    send(8'hA5);
    bfm(4, 1'b1, 0, got);
    low3 = got[2:0];
    chkv("abort_first_bits", 32'(low3), 32'(3'b101));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk1("abort_clk_oe", ps2_clk_oe, 1'b0);
    chk1("abort_data_oe", ps2_data_oe, 1'b0);
    chk1("abort_tx_ready", tx_ready, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    dev_clk = 1'b1;
    repeat (50) @(negedge clk);

    fork
      run_frame(8'hED, 0, 5, got);
      begin
        repeat (100) @(negedge clk);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    chkv("glitch_busy_valid_bits", 32'(got), 32'(10'b11_1110_1101));
    repeat (20) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      m = int'($urandom_range(0, 1));
      run_frame(b, m, 0, got);
      repeat (int'($urandom_range(1, 40))) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    n_fail++;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion earlier", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
